// File: rtl/parking_gate_if.sv
// Request/status bundle between the gate sensors, the occupancy counter and the
// gate arbiter. Requests are one-cycle pulses; inc/dec/deny/timeout are one-cycle strobes.
interface parking_gate_if #(
   parameter int COUNT_W = 3
);
   logic               entry_req;
   logic               exit_req;
   logic               car_clear;
   logic [COUNT_W-1:0] count;
   logic               gate_open;
   logic               inc;
   logic               dec;
   logic               deny_in;
   logic               deny_out;
   logic               timeout;
   logic               full;

   // Handshake: no valid/ready pair. A request pulse is always accepted (latched into a
   // single-depth pending flag); each strobe is high for exactly one cycle and needs no ack.
   modport master (
      output entry_req, exit_req, car_clear, count,
      input  gate_open, inc, dec, deny_in, deny_out, timeout, full
   );

   modport slave (
      input  entry_req, exit_req, car_clear, count,
      output gate_open, inc, dec, deny_in, deny_out, timeout, full
   );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Single-lane barrier arbiter: round-robins entry/exit requests over one gate, enforces
// capacity, aborts stuck passages and issues the only inc/dec strobes to the counter.
module parking_gate_arbiter #(
   parameter int COUNT_W      = 3,
   parameter int CAPACITY     = 7,
   parameter int OPEN_CYCLES  = 12000000,
   parameter int GUARD_CYCLES = 6000000
) (
   input  logic              clk,
   input  logic              rst,
   parking_gate_if.slave     bus,
   output logic [1:0]        state_dbg
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_OPEN   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_GUARD  = 2'd3;

   localparam logic DIR_IN  = 1'b1;
   localparam logic DIR_OUT = 1'b0;

   localparam int T_MAX = (OPEN_CYCLES > GUARD_CYCLES) ? OPEN_CYCLES : GUARD_CYCLES;
   localparam int TW    = $clog2(T_MAX + 1);

   localparam logic [TW-1:0]      OPEN_LAST  = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0]      GUARD_LAST = TW'(GUARD_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CAP_C      = COUNT_W'(CAPACITY);

   logic [1:0]    state, next_state;
   logic [TW-1:0] timer, timer_n;
   logic          dir, last_served;
   logic          pend_in, pend_out;
   logic          deny_in_q, deny_out_q, timeout_q;

   logic el_in, el_out;
   logic grant, grant_dir;
   logic clr_in, clr_out;
   logic deny_in_n, deny_out_n, timeout_n;

   always_comb begin
      el_in      = pend_in && (bus.count < CAP_C);
      el_out     = pend_out && (bus.count != '0);
      grant      = 1'b0;
      grant_dir  = DIR_OUT;
      clr_in     = 1'b0;
      clr_out    = 1'b0;
      deny_in_n  = 1'b0;
      deny_out_n = 1'b0;
      timeout_n  = 1'b0;
      next_state = state;
      timer_n    = timer;

      case (state)
         S_IDLE: begin
            if (el_in && el_out) begin
               grant     = 1'b1;
               grant_dir = ~last_served;
            end else if (el_in) begin
               grant     = 1'b1;
               grant_dir = DIR_IN;
            end else if (el_out) begin
               grant     = 1'b1;
               grant_dir = DIR_OUT;
            end else if (pend_in) begin
               // pend_in without el_in means the lot is full and nobody can leave
               clr_in    = 1'b1;
               deny_in_n = 1'b1;
            end else if (pend_out) begin
               clr_out    = 1'b1;
               deny_out_n = 1'b1;
            end
            if (grant) begin
               next_state = S_OPEN;
               timer_n    = '0;
            end
         end
         S_OPEN: begin
            if (bus.car_clear) begin
               next_state = S_COMMIT;
               timer_n    = '0;
            end else if (timer == OPEN_LAST) begin
               timeout_n  = 1'b1;
               clr_in     = (dir == DIR_IN);
               clr_out    = (dir == DIR_OUT);
               next_state = S_GUARD;
               timer_n    = '0;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         S_COMMIT: begin
            clr_in     = (dir == DIR_IN);
            clr_out    = (dir == DIR_OUT);
            next_state = S_GUARD;
            timer_n    = '0;
         end
         S_GUARD: begin
            if (timer == GUARD_LAST) begin
               next_state = S_IDLE;
               timer_n    = '0;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: begin
            next_state = S_IDLE;
            timer_n    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         dir         <= DIR_OUT;
         last_served <= DIR_OUT;
         pend_in     <= 1'b0;
         pend_out    <= 1'b0;
         deny_in_q   <= 1'b0;
         deny_out_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state      <= next_state;
         timer      <= timer_n;
         deny_in_q  <= deny_in_n;
         deny_out_q <= deny_out_n;
         timeout_q  <= timeout_n;
         if (grant) begin
            dir         <= grant_dir;
            last_served <= grant_dir;
         end
         // a new request in the same cycle as a clear keeps the flag set
         pend_in  <= bus.entry_req | (pend_in & ~clr_in);
         pend_out <= bus.exit_req | (pend_out & ~clr_out);
      end
   end

   assign bus.gate_open = (state == S_OPEN);
   assign bus.inc       = (state == S_COMMIT) && (dir == DIR_IN);
   assign bus.dec       = (state == S_COMMIT) && (dir == DIR_OUT);
   assign bus.deny_in   = deny_in_q;
   assign bus.deny_out  = deny_out_q;
   assign bus.timeout   = timeout_q;
   assign bus.full      = (bus.count >= CAP_C);
   assign state_dbg     = state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: timeline model of passages checked every cycle,
// plus literal event counts and latencies per scenario.
module tb_parking_gate_arbiter;

   localparam int COUNT_W      = 3;
   localparam int CAPACITY     = 7;
   localparam int OPEN_CYCLES  = 8;
   localparam int GUARD_CYCLES = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_dbg;

   parking_gate_if #(.COUNT_W(COUNT_W)) bus ();

   parking_gate_arbiter #(
      .COUNT_W      (COUNT_W),
      .CAPACITY     (CAPACITY),
      .OPEN_CYCLES  (OPEN_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Timeline model. Cycle numbers are the index of the clock edge that samples an input
   // or updates an output. A passage is a grant edge, an open window of up to OPEN_CYCLES
   // edges, then a closed hold; the next decision edge is computed arithmetically.
   bit model_on = 1'b0;
   bit m_pend_in, m_pend_out, m_last_in, m_dir_in;
   int open_since = -1;
   int free_at    = 0;
   int clr_edge   = -1;
   bit e_gate, e_inc, e_dec, e_den_in, e_den_out, e_to;

   function automatic void model_step();
      bit clr_in, clr_out, el_in, el_out, go_in;
      clr_in    = 1'b0;
      clr_out   = 1'b0;
      e_inc     = 1'b0;
      e_dec     = 1'b0;
      e_den_in  = 1'b0;
      e_den_out = 1'b0;
      e_to      = 1'b0;
      if (rst) begin
         model_on   = 1'b1;
         m_pend_in  = 1'b0;
         m_pend_out = 1'b0;
         m_last_in  = 1'b0;
         open_since = -1;
         clr_edge   = -1;
         free_at    = cyc + 1;
         e_gate     = 1'b0;
         return;
      end
      if (!model_on) return;
      if (open_since >= 0) begin
         if (bus.car_clear) begin
            e_inc      = m_dir_in;
            e_dec      = !m_dir_in;
            clr_edge   = cyc + 1;
            free_at    = cyc + 2 + GUARD_CYCLES;
            open_since = -1;
            e_gate     = 1'b0;
         end else if (cyc - open_since == OPEN_CYCLES) begin
            e_to       = 1'b1;
            clr_in     = m_dir_in;
            clr_out    = !m_dir_in;
            free_at    = cyc + 1 + GUARD_CYCLES;
            open_since = -1;
            e_gate     = 1'b0;
         end
      end else if (cyc == clr_edge) begin
         clr_in  = m_dir_in;
         clr_out = !m_dir_in;
      end else if (cyc >= free_at) begin
         el_in  = m_pend_in && (int'(bus.count) < CAPACITY);
         el_out = m_pend_out && (int'(bus.count) != 0);
         if (el_in || el_out) begin
            go_in      = (el_in && el_out) ? !m_last_in : el_in;
            m_dir_in   = go_in;
            m_last_in  = go_in;
            open_since = cyc;
            e_gate     = 1'b1;
         end else if (m_pend_in) begin
            e_den_in = 1'b1;
            clr_in   = 1'b1;
         end else if (m_pend_out) begin
            e_den_out = 1'b1;
            clr_out   = 1'b1;
         end
      end
      m_pend_in  = bus.entry_req || (m_pend_in && !clr_in);
      m_pend_out = bus.exit_req || (m_pend_out && !clr_out);
   endfunction

   // event counters for literal per-scenario expectations
   int gate_cycles, inc_cnt, dec_cnt, deny_in_cnt, deny_out_cnt, timeout_cnt;
   int inc_cyc, dec_cyc, deny_cyc;

   task automatic clear_counters();
      gate_cycles  = 0;
      inc_cnt      = 0;
      dec_cnt      = 0;
      deny_in_cnt  = 0;
      deny_out_cnt = 0;
      timeout_cnt  = 0;
      inc_cyc      = -1;
      dec_cyc      = -1;
      deny_cyc     = -1;
   endtask

   // model step on the edge, compare and monitor 1 time unit later
   always @(posedge clk) begin
      cyc++;
      model_step();
      #1;
      if (model_on) begin
         chk("gate_open", bus.gate_open, e_gate);
         chk("inc",       bus.inc,       e_inc);
         chk("dec",       bus.dec,       e_dec);
         chk("deny_in",   bus.deny_in,   e_den_in);
         chk("deny_out",  bus.deny_out,  e_den_out);
         chk("timeout",   bus.timeout,   e_to);
         chk("full",      bus.full,      int'(bus.count) >= CAPACITY);
      end
      if (bus.gate_open) gate_cycles++;
      if (bus.inc) begin
         inc_cnt++;
         if (inc_cyc < 0) inc_cyc = cyc;
      end
      if (bus.dec) begin
         dec_cnt++;
         if (dec_cyc < 0) dec_cyc = cyc;
      end
      if (bus.deny_in) begin
         deny_in_cnt++;
         if (deny_cyc < 0) deny_cyc = cyc;
      end
      if (bus.deny_out) begin
         deny_out_cnt++;
         if (deny_cyc < 0) deny_cyc = cyc;
      end
      if (bus.timeout) timeout_cnt++;
   end

   // driver tasks: all start and end on a falling edge
   task automatic pulse_req(input logic e, input logic x, output int req_cyc);
      bus.entry_req = e;
      bus.exit_req  = x;
      req_cyc       = cyc + 1;
      @(negedge clk);
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
   endtask

   task automatic wait_gate(input string name);
      int n;
      n = 0;
      while (bus.gate_open !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.gate_open !== 1'b1) begin
         errors++;
         $display("FAIL %s gate never opened within 40 cycles", name);
      end
   endtask

   task automatic serve(input string name, input int hold);
      wait_gate(name);
      repeat (hold) @(negedge clk);
      bus.car_clear = 1'b1;
      @(negedge clk);
      bus.car_clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rq;
      rst           = 1'b1;
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
      bus.car_clear = 1'b0;
      bus.count     = '0;
      clear_counters();
      idle(3);
      rst = 1'b0;
      chk("rst_gate_open", bus.gate_open, 1'b0);
      chk("rst_inc",       bus.inc,       1'b0);
      chk("rst_dec",       bus.dec,       1'b0);
      chk("rst_timeout",   bus.timeout,   1'b0);
      idle(2);

      // 1: entry with count 3, car clears after three open cycles
      bus.count = 3'd3;
      clear_counters();
      pulse_req(1'b1, 1'b0, rq);
      serve("t1", 2);
      idle(8);
      chk_int("t1_gate_cycles", gate_cycles, 3);
      chk_int("t1_inc_cnt", inc_cnt, 1);
      chk_int("t1_dec_cnt", dec_cnt, 0);
      chk_int("t1_inc_latency", inc_cyc - rq, 4);

      // 2: lot full, entry refused
      bus.count = 3'd7;
      clear_counters();
      pulse_req(1'b1, 1'b0, rq);
      idle(8);
      chk_int("t2_deny_in_cnt", deny_in_cnt, 1);
      chk_int("t2_deny_latency", deny_cyc - rq, 1);
      chk_int("t2_gate_cycles", gate_cycles, 0);
      chk_int("t2_inc_cnt", inc_cnt, 0);

      // 3: lot empty, exit refused; then a real exit
      bus.count = 3'd0;
      clear_counters();
      pulse_req(1'b0, 1'b1, rq);
      idle(6);
      chk_int("t3_deny_out_cnt", deny_out_cnt, 1);
      chk_int("t3_gate_cycles", gate_cycles, 0);
      bus.count = 3'd4;
      clear_counters();
      pulse_req(1'b0, 1'b1, rq);
      serve("t3", 1);
      idle(8);
      chk_int("t3_dec_cnt", dec_cnt, 1);
      chk_int("t3_inc_cnt", inc_cnt, 0);

      // 4: simultaneous requests after an exit: entry first, then exit
      bus.count = 3'd4;
      clear_counters();
      pulse_req(1'b1, 1'b1, rq);
      serve("t4a", 1);
      bus.count = 3'd5;
      serve("t4b", 1);
      bus.count = 3'd4;
      idle(8);
      chk_int("t4_inc_cnt", inc_cnt, 1);
      chk_int("t4_dec_cnt", dec_cnt, 1);
      chk_int("t4_in_before_out", int'(inc_cyc < dec_cyc), 1);

      // 5: car never clears, passage aborted
      bus.count = 3'd2;
      clear_counters();
      pulse_req(1'b1, 1'b0, rq);
      idle(25);
      chk_int("t5_gate_cycles", gate_cycles, 8);
      chk_int("t5_timeout_cnt", timeout_cnt, 1);
      chk_int("t5_inc_cnt", inc_cnt, 0);

      // 6: full lot with both requests: exit first, entry once a space frees
      bus.count = 3'd7;
      clear_counters();
      pulse_req(1'b1, 1'b1, rq);
      serve("t6a", 1);
      bus.count = 3'd6;
      chk_int("t6_dec_cnt", dec_cnt, 1);
      chk_int("t6_inc_before", inc_cnt, 0);
      serve("t6b", 1);
      chk_int("t6_inc_cnt", inc_cnt, 1);
      pulse_req(1'b1, 1'b0, rq);
      wait_gate("t6c");
      clear_counters();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_gate_after_rst", bus.gate_open, 1'b0);
      idle(15);
      chk_int("t6_rst_gate_cycles", gate_cycles, 0);
      chk_int("t6_rst_inc_cnt", inc_cnt, 0);
      chk_int("t6_rst_dec_cnt", dec_cnt, 0);
      chk_int("t6_rst_timeout_cnt", timeout_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
